// File: rtl/riscv8_pkg.sv
// Shared constants, ALU op encoding and pipeline-register payloads for the 8-bit RISC-V core.
package riscv8_pkg;

    localparam int unsigned XLEN       = 8;
    localparam int unsigned IMEM_DEPTH = 1024;
    localparam int unsigned DMEM_DEPTH = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned PC_W       = 10;
    localparam int unsigned DADDR_W    = 5;
    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned INSTR_W    = 32;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_XOR     = 3'b100;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR
    } alu_op_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    // Unused source indices are zeroed in decode so they never match a forward.
    typedef struct packed {
        logic                 reg_write;
        logic                 mem_write;
        logic                 mem_to_reg;
        logic                 alu_src_imm;
        alu_op_t              alu_op;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [XLEN-1:0]      imm;
    } id_ex_t;

    typedef struct packed {
        logic                 reg_write;
        logic                 mem_write;
        logic                 mem_to_reg;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      store_data;
    } ex_mem_t;

    typedef struct packed {
        logic                 reg_write;
        logic                 mem_to_reg;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      load_data;
    } mem_wb_t;

endpackage

// File: rtl/riscv8_alu.sv
// 8-bit combinational ALU.
//   i_a, i_b : operands
//   i_op     : operation select
//   o_result : result, modulo 256
module riscv8_alu
    import riscv8_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  alu_op_t         i_op,
    output logic [XLEN-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/riscv8_pipeline_top.sv
// Five-stage in-order RV32I-subset core with an 8-bit datapath.
//   clock           : rising-edge clock
//   reset           : async active-high; clears pipeline, PC, RF (x[i]=i), DMEM (dmem[i]=i)
//   reset_IF_memory : sync clear of the whole instruction memory
//   instruction_in  : word written into IMEM while rw=0
//   rw              : 0 = load IMEM (fetch injects NOPs), 1 = run
//   PC_write        : IMEM write address while rw=0
//   write_reg_data  : write-back data while the WB stage writes a register, else 0
module riscv8_pipeline_top
    import riscv8_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               reset_IF_memory,
    input  logic [INSTR_W-1:0] instruction_in,
    input  logic               rw,
    input  logic [PC_W-1:0]    PC_write,
    output logic [XLEN-1:0]    write_reg_data
);

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];
    logic [XLEN-1:0]    r_rf   [NUM_REGS];
    logic [XLEN-1:0]    r_dmem [DMEM_DEPTH];

    if_id_t  r_if_id;
    id_ex_t  r_id_ex;
    ex_mem_t r_ex_mem;
    mem_wb_t r_mem_wb;

    logic [INSTR_W-1:0]   w_if_instr;
    logic [6:0]           w_opcode;
    logic [2:0]           w_funct3;
    logic [6:0]           w_funct7;
    logic [REG_IDX_W-1:0] w_rs1;
    logic [REG_IDX_W-1:0] w_rs2;
    logic [REG_IDX_W-1:0] w_rd;
    logic [XLEN-1:0]      w_imm_i;
    logic [XLEN-1:0]      w_imm_s;
    logic [XLEN-1:0]      w_rs1_data;
    logic [XLEN-1:0]      w_rs2_data;
    logic                 w_r_legal;
    alu_op_t              w_r_op;
    logic                 w_use_rs1;
    logic                 w_use_rs2;
    logic                 w_stall;
    id_ex_t               w_id_ex;
    logic [XLEN-1:0]      w_fwd_a;
    logic [XLEN-1:0]      w_fwd_b;
    logic [XLEN-1:0]      w_alu_b;
    logic [XLEN-1:0]      w_alu_result;
    ex_mem_t              w_ex_mem;
    mem_wb_t              w_mem_wb;
    logic [XLEN-1:0]      w_wb_data;
    logic                 w_wb_we;

    // IMEM: clear has priority over load; untouched by the core reset.
    always_ff @(posedge clock) begin
        if (reset_IF_memory) begin
            for (int i = 0; i < int'(IMEM_DEPTH); i++) begin
                r_imem[i] <= '0;
            end
        end else if (!rw) begin
            r_imem[PC_write] <= instruction_in;
        end
    end

    // Fetch: load mode feeds NOPs so in-flight work drains.
    assign w_if_instr = rw ? r_imem[r_pc] : '0;

    // Field extraction; immediates keep only the low 8 bits of the sign-extended value.
    assign w_opcode = r_if_id.instr[6:0];
    assign w_funct3 = r_if_id.instr[14:12];
    assign w_funct7 = r_if_id.instr[31:25];
    assign w_rs1    = r_if_id.instr[19:15];
    assign w_rs2    = r_if_id.instr[24:20];
    assign w_rd     = r_if_id.instr[11:7];
    assign w_imm_i  = r_if_id.instr[27:20];
    assign w_imm_s  = {r_if_id.instr[27:25], r_if_id.instr[11:7]};

    // Write-back bookkeeping; x0 is never written.
    assign w_wb_data      = r_mem_wb.mem_to_reg ? r_mem_wb.load_data : r_mem_wb.alu_result;
    assign w_wb_we        = r_mem_wb.reg_write && (r_mem_wb.rd != '0);
    assign write_reg_data = r_mem_wb.reg_write ? w_wb_data : '0;

    // Register read with write-first bypass from WB.
    assign w_rs1_data = (w_rs1 == '0) ? '0 :
                        (w_wb_we && r_mem_wb.rd == w_rs1) ? w_wb_data : r_rf[w_rs1];
    assign w_rs2_data = (w_rs2 == '0) ? '0 :
                        (w_wb_we && r_mem_wb.rd == w_rs2) ? w_wb_data : r_rf[w_rs2];

    // R-type function decode.
    always_comb begin
        w_r_legal = 1'b1;
        w_r_op    = ALU_ADD;
        case (w_funct3)
            F3_ADD_SUB: begin
                if (w_funct7 == F7_SUB) begin
                    w_r_op = ALU_SUB;
                end else if (w_funct7 != F7_ADD) begin
                    w_r_legal = 1'b0;
                end
            end
            F3_AND:  w_r_op = ALU_AND;
            F3_OR:   w_r_op = ALU_OR;
            F3_XOR:  w_r_op = ALU_XOR;
            default: w_r_legal = 1'b0;
        endcase
    end

    // Main decode; anything unrecognised becomes an all-zero bubble.
    always_comb begin
        w_id_ex   = '0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OP_R: begin
                if (w_r_legal) begin
                    w_id_ex.reg_write = 1'b1;
                    w_id_ex.alu_op    = w_r_op;
                    w_use_rs1         = 1'b1;
                    w_use_rs2         = 1'b1;
                end
            end
            OP_LD: begin
                w_id_ex.reg_write   = 1'b1;
                w_id_ex.mem_to_reg  = 1'b1;
                w_id_ex.alu_src_imm = 1'b1;
                w_id_ex.imm         = w_imm_i;
                w_use_rs1           = 1'b1;
            end
            OP_SD: begin
                w_id_ex.mem_write   = 1'b1;
                w_id_ex.alu_src_imm = 1'b1;
                w_id_ex.imm         = w_imm_s;
                w_use_rs1           = 1'b1;
                w_use_rs2           = 1'b1;
            end
            default: ;
        endcase
        w_id_ex.rs1      = w_use_rs1 ? w_rs1 : '0;
        w_id_ex.rs2      = w_use_rs2 ? w_rs2 : '0;
        w_id_ex.rd       = w_id_ex.reg_write ? w_rd : '0;
        w_id_ex.rs1_data = w_use_rs1 ? w_rs1_data : '0;
        w_id_ex.rs2_data = w_use_rs2 ? w_rs2_data : '0;
    end

    // Load-use: a load in EX cannot forward in time, so hold IF/ID for one cycle.
    assign w_stall = r_id_ex.mem_to_reg && (r_id_ex.rd != '0) &&
                     ((w_use_rs1 && (w_rs1 == r_id_ex.rd)) ||
                      (w_use_rs2 && (w_rs2 == r_id_ex.rd)));

    // Operand forwarding: younger EX/MEM result wins over MEM/WB.
    always_comb begin
        w_fwd_a = r_id_ex.rs1_data;
        if (r_ex_mem.reg_write && (r_ex_mem.rd != '0) && (r_ex_mem.rd == r_id_ex.rs1)) begin
            w_fwd_a = r_ex_mem.alu_result;
        end else if (w_wb_we && (r_mem_wb.rd == r_id_ex.rs1)) begin
            w_fwd_a = w_wb_data;
        end
        w_fwd_b = r_id_ex.rs2_data;
        if (r_ex_mem.reg_write && (r_ex_mem.rd != '0) && (r_ex_mem.rd == r_id_ex.rs2)) begin
            w_fwd_b = r_ex_mem.alu_result;
        end else if (w_wb_we && (r_mem_wb.rd == r_id_ex.rs2)) begin
            w_fwd_b = w_wb_data;
        end
    end

    assign w_alu_b = r_id_ex.alu_src_imm ? r_id_ex.imm : w_fwd_b;

    riscv8_alu u_alu (
        .i_a      (w_fwd_a),
        .i_b      (w_alu_b),
        .i_op     (r_id_ex.alu_op),
        .o_result (w_alu_result)
    );

    // EX/MEM and MEM/WB payloads.
    always_comb begin
        w_ex_mem            = '0;
        w_ex_mem.reg_write  = r_id_ex.reg_write;
        w_ex_mem.mem_write  = r_id_ex.mem_write;
        w_ex_mem.mem_to_reg = r_id_ex.mem_to_reg;
        w_ex_mem.rd         = r_id_ex.rd;
        w_ex_mem.alu_result = w_alu_result;
        w_ex_mem.store_data = w_fwd_b;

        w_mem_wb            = '0;
        w_mem_wb.reg_write  = r_ex_mem.reg_write;
        w_mem_wb.mem_to_reg = r_ex_mem.mem_to_reg;
        w_mem_wb.rd         = r_ex_mem.rd;
        w_mem_wb.alu_result = r_ex_mem.alu_result;
        w_mem_wb.load_data  = r_dmem[r_ex_mem.alu_result[DADDR_W-1:0]];
    end

    // PC and pipeline registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc     <= '0;
            r_if_id  <= '0;
            r_id_ex  <= '0;
            r_ex_mem <= '0;
            r_mem_wb <= '0;
        end else begin
            if (rw && !w_stall) begin
                r_pc <= r_pc + PC_W'(1);
            end
            if (!w_stall) begin
                r_if_id.instr <= w_if_instr;
            end
            if (w_stall) begin
                r_id_ex <= '0;
            end else begin
                r_id_ex <= w_id_ex;
            end
            r_ex_mem <= w_ex_mem;
            r_mem_wb <= w_mem_wb;
        end
    end

    // Register file.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_rf[i] <= XLEN'(i);
            end
        end else if (w_wb_we) begin
            r_rf[r_mem_wb.rd] <= w_wb_data;
        end
    end

    // Data memory.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
                r_dmem[i] <= XLEN'(i);
            end
        end else if (r_ex_mem.mem_write) begin
            r_dmem[r_ex_mem.alu_result[DADDR_W-1:0]] <= r_ex_mem.store_data;
        end
    end

endmodule

// File: tb/tb_riscv8_pipeline_top.sv
// Directed bench for riscv8_pipeline_top: loads small programs, runs them and
// checks write_reg_data cycle by cycle against hand-computed traces.
module tb_riscv8_pipeline_top;

    logic        clock           = 1'b0;
    logic        reset           = 1'b1;
    logic        reset_IF_memory = 1'b0;
    logic [31:0] instruction_in  = '0;
    logic        rw              = 1'b0;
    logic [9:0]  PC_write        = '0;
    logic [7:0]  write_reg_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] trace [32];

    riscv8_pipeline_top dut (
        .clock           (clock),
        .reset           (reset),
        .reset_IF_memory (reset_IF_memory),
        .instruction_in  (instruction_in),
        .rw              (rw),
        .PC_write        (PC_write),
        .write_reg_data  (write_reg_data)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return enc_r(7'b0000000, 3'b000, rd, rs1, rs2);
    endfunction

    function automatic logic [31:0] enc_ld(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm, rs1, 3'b011, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sd(input logic [4:0] rs2, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
    endfunction

    task automatic begin_load();
        reset = 1'b1;
        rw    = 1'b0;
    endtask

    task automatic clear_imem();
        reset_IF_memory = 1'b1;
        @(posedge clock); #1;
        reset_IF_memory = 1'b0;
    endtask

    task automatic write_word(input logic [9:0] addr, input logic [31:0] word);
        PC_write       = addr;
        instruction_in = word;
        @(posedge clock); #1;
    endtask

    task automatic restart();
        instruction_in = '0;
        PC_write       = 10'd1023;
        reset          = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Cycle k of the trace is the k-th cycle after reset release; bit k of mask is rw.
    task automatic run_trace(input int n, input logic [31:0] mask);
        for (int k = 0; k < n; k++) begin
            rw = mask[k];
            @(negedge clock);
            trace[k] = write_reg_data;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        @(posedge clock); @(posedge clock); #1;
        checks++;
        if (write_reg_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: got %02h expected 00", write_reg_data);
        end
    endtask

    task automatic test_load_use();
        logic [7:0] exp [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                 8'h03, 8'h0C, 8'h00, 8'h0F, 8'h00};
        begin_load();
        clear_imem();
        write_word(10'd1, enc_ld(5'd1, 5'd2, 12'd1));
        write_word(10'd2, enc_ld(5'd3, 5'd10, 12'd2));
        write_word(10'd3, enc_add(5'd6, 5'd1, 5'd3));
        restart();
        run_trace(10, 32'hFFFF_FFFF);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (trace[k] !== exp[k]) begin
                failures++;
                $display("FAIL load_use cycle %0d: got %02h expected %02h", k, trace[k], exp[k]);
            end
        end
    endtask

    task automatic test_forward();
        logic [7:0] exp [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h03,
                                8'h06, 8'h09, 8'h0C, 8'h00};
        begin_load();
        clear_imem();
        write_word(10'd0, enc_add(5'd5, 5'd1, 5'd2));
        write_word(10'd1, enc_add(5'd7, 5'd5, 5'd5));
        write_word(10'd2, enc_add(5'd8, 5'd5, 5'd7));
        write_word(10'd3, enc_add(5'd9, 5'd8, 5'd5));
        restart();
        run_trace(9, 32'hFFFF_FFFF);
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (trace[k] !== exp[k]) begin
                failures++;
                $display("FAIL forward cycle %0d: got %02h expected %02h", k, trace[k], exp[k]);
            end
        end
    endtask

    task automatic test_forward_priority();
        logic [7:0] exp [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h04, 8'h04, 8'h00};
        begin_load();
        clear_imem();
        write_word(10'd0, enc_add(5'd5, 5'd1, 5'd1));
        write_word(10'd1, enc_add(5'd5, 5'd2, 5'd2));
        write_word(10'd2, enc_add(5'd6, 5'd5, 5'd0));
        restart();
        run_trace(8, 32'hFFFF_FFFF);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (trace[k] !== exp[k]) begin
                failures++;
                $display("FAIL fwd_priority cycle %0d: got %02h expected %02h", k, trace[k], exp[k]);
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [7:0] exp [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h0B,
                                 8'h03, 8'h06, 8'h00, 8'h00, 8'h06, 8'h00};
        begin_load();
        clear_imem();
        write_word(10'd0, enc_r(7'b0100000, 3'b000, 5'd4, 5'd1, 5'd2));
        write_word(10'd1, enc_r(7'b0000000, 3'b110, 5'd4, 5'd8, 5'd3));
        write_word(10'd2, enc_r(7'b0000000, 3'b111, 5'd4, 5'd7, 5'd3));
        write_word(10'd3, enc_r(7'b0000000, 3'b100, 5'd4, 5'd5, 5'd3));
        write_word(10'd4, enc_r(7'b0000000, 3'b001, 5'd4, 5'd1, 5'd2));
        write_word(10'd5, enc_r(7'b0000001, 3'b000, 5'd4, 5'd1, 5'd2));
        write_word(10'd6, enc_add(5'd4, 5'd4, 5'd0));
        restart();
        run_trace(12, 32'hFFFF_FFFF);
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (trace[k] !== exp[k]) begin
                failures++;
                $display("FAIL alu_ops cycle %0d: got %02h expected %02h", k, trace[k], exp[k]);
            end
        end
    endtask

    task automatic test_mem_x0();
        logic [7:0] exp [13] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09, 8'h03,
                                 8'h03, 8'h04, 8'h05, 8'h03, 8'h09, 8'h00};
        begin_load();
        clear_imem();
        write_word(10'd0, enc_sd(5'd9, 5'd1, 12'd0));
        write_word(10'd1, enc_ld(5'd11, 5'd0, 12'd1));
        write_word(10'd2, enc_add(5'd0, 5'd1, 5'd2));
        write_word(10'd3, enc_add(5'd12, 5'd0, 5'd3));
        write_word(10'd4, enc_add(5'd13, 5'd0, 5'd4));
        write_word(10'd5, enc_add(5'd14, 5'd0, 5'd5));
        write_word(10'd6, enc_ld(5'd15, 5'd4, 12'hFFF));
        write_word(10'd7, enc_ld(5'd16, 5'd0, 12'd33));
        restart();
        run_trace(13, 32'hFFFF_FFFF);
        for (int k = 0; k < 13; k++) begin
            checks++;
            if (trace[k] !== exp[k]) begin
                failures++;
                $display("FAIL mem_x0 cycle %0d: got %02h expected %02h", k, trace[k], exp[k]);
            end
        end
    endtask

    task automatic test_rw_freeze();
        logic [7:0] exp [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00,
                                 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
        begin_load();
        clear_imem();
        write_word(10'd0, enc_add(5'd5, 5'd1, 5'd2));
        write_word(10'd1, enc_add(5'd6, 5'd1, 5'd1));
        restart();
        run_trace(12, 32'hFFFF_FFC1);
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (trace[k] !== exp[k]) begin
                failures++;
                $display("FAIL rw_freeze cycle %0d: got %02h expected %02h", k, trace[k], exp[k]);
            end
        end
    endtask

    task automatic test_imem_clear();
        begin_load();
        write_word(10'd0, enc_add(5'd5, 5'd1, 5'd2));
        write_word(10'd1, enc_add(5'd6, 5'd1, 5'd1));
        // Clear asserted while a load write to word 1 is also requested.
        clear_imem();
        restart();
        run_trace(12, 32'hFFFF_FFFF);
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (trace[k] !== 8'h00) begin
                failures++;
                $display("FAIL imem_clear cycle %0d: got %02h expected 00", k, trace[k]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] exp [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h06, 8'h03, 8'h00, 8'h00};
        begin_load();
        clear_imem();
        write_word(10'd0, enc_add(5'd15, 5'd6, 5'd0));
        write_word(10'd1, enc_add(5'd6, 5'd1, 5'd2));
        write_word(10'd4, enc_add(5'd15, 5'd6, 5'd0));
        restart();
        run_trace(8, 32'hFFFF_FFFF);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (trace[k] !== exp[k]) begin
                failures++;
                $display("FAIL midrun_first cycle %0d: got %02h expected %02h", k, trace[k], exp[k]);
            end
        end
        @(negedge clock);
        checks++;
        if (write_reg_data !== 8'h03) begin
            failures++;
            $display("FAIL midrun_before_reset: got %02h expected 03", write_reg_data);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (write_reg_data !== 8'h00) begin
            failures++;
            $display("FAIL midrun_async_flush: got %02h expected 00", write_reg_data);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        run_trace(6, 32'hFFFF_FFFF);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (trace[k] !== exp[k]) begin
                failures++;
                $display("FAIL midrun_restart cycle %0d: got %02h expected %02h", k, trace[k], exp[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_forward_priority();
        test_alu_ops();
        test_mem_x0();
        test_rw_freeze();
        test_imem_clear();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
